alu_seq: RTL

- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Same opcode map, flags and cin/bin semantics.
- Adds registered outputs, valid/ready flow control, and iterative multi-cycle multiply and divide. Divide returns a remainder and flags divide-by-zero.
- Sits between the operand/register-read stage and writeback; holds one operation at a time.

---
 rtl/alu_seq_if.sv | 20 ++
 rtl/alu_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the operand stage, alu_seq and writeback.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       opcode;
  logic             cin, bin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result, remainder;
  logic             zero, sign, carry, overflow, parity, div_by_zero, illegal_op;
  modport master (
    output in_valid, a, b, opcode, cin, bin, out_ready,
    input  in_ready, out_valid, result, remainder,
           zero, sign, carry, overflow, parity, div_by_zero, illegal_op
  );
  modport slave (
    input  in_valid, a, b, opcode, cin, bin, out_ready,
    output in_ready, out_valid, result, remainder,
           zero, sign, carry, overflow, parity, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results and iterative multiply/divide.
module alu_seq #(parameter int WIDTH = 32) (
  input logic   clk,
  input logic   rst_n,
  alu_seq_if.slave s
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     add_s, sub_d, mul_s, trial;
  logic [WIDTH-1:0]   bq, r_c, rem_c;
  logic               is_mul, c_c, v_c, dz_c, il_c, accept, multi, fin;
  always_comb begin
    accept = s.in_ready && s.in_valid;
    multi  = s.opcode == 4'd9 || (s.opcode == 4'd10 && s.b != '0);
    fin    = (state == IDLE && accept && !multi) || (state == CALC && cnt == CNT_W'(1));
    add_s  = {1'b0, s.a} + {1'b0, s.b} + {{WIDTH{1'b0}}, s.cin};
    sub_d  = {1'b0, s.a} - {1'b0, s.b} - {{WIDTH{1'b0}}, s.bin};
    // acc holds {hi, lo}: mul = {partial product, remaining multiplier}, div = {partial remainder, quotient}
    mul_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bq} : '0);
    sh     = {acc, 1'b0};
    trial  = sh[2*WIDTH:WIDTH] - {1'b0, bq};
    nxt    = is_mul ? {mul_s, acc[WIDTH-1:1]}
                    : (trial[WIDTH] ? sh[2*WIDTH-1:0] : {trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1});
    r_c    = '0;
    rem_c  = '0;
    c_c    = 1'b0;
    v_c    = 1'b0;
    dz_c   = 1'b0;
    il_c   = 1'b0;
    case (s.opcode)
      4'd0: begin
        {c_c, r_c} = add_s;
        v_c = (s.a[WIDTH-1] == s.b[WIDTH-1]) && (add_s[WIDTH-1] != s.a[WIDTH-1]);
      end
      4'd1: begin
        {c_c, r_c} = sub_d;
        v_c = (s.a[WIDTH-1] != s.b[WIDTH-1]) && (sub_d[WIDTH-1] != s.a[WIDTH-1]);
      end
      4'd2:  r_c = ~s.a;
      4'd3:  r_c = s.a & s.b;
      4'd4:  r_c = s.a | s.b;
      4'd5:  r_c = ~(s.a | s.b);
      4'd6:  r_c = ~(s.a & s.b);
      4'd7:  r_c = s.a ^ s.b;
      4'd8:  r_c = ~(s.a ^ s.b);
      4'd10: begin
        r_c   = '1;
        rem_c = s.a;
        dz_c  = 1'b1;
      end
      4'd11: r_c = WIDTH'(s.a == s.b);
      4'd12: r_c = WIDTH'(s.a > s.b);
      4'd13: {c_c, r_c} = {s.a, 1'b0};
      4'd14: {r_c, c_c} = {1'b0, s.a};
      4'd15: il_c = 1'b1;
      default: ;
    endcase
    if (state == CALC) begin
      r_c   = nxt[WIDTH-1:0];
      rem_c = is_mul ? '0 : nxt[2*WIDTH-1:WIDTH];
      c_c   = 1'b0;
      v_c   = is_mul && |nxt[2*WIDTH-1:WIDTH];
      dz_c  = 1'b0;
      il_c  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      bq            <= '0;
      is_mul        <= 1'b0;
      s.in_ready    <= 1'b1;
      s.out_valid   <= 1'b0;
      s.result      <= '0;
      s.remainder   <= '0;
      s.zero        <= 1'b0;
      s.sign        <= 1'b0;
      s.carry       <= 1'b0;
      s.overflow    <= 1'b0;
      s.parity      <= 1'b0;
      s.div_by_zero <= 1'b0;
      s.illegal_op  <= 1'b0;
    end else begin
      if (fin) begin
        state         <= DONE;
        s.out_valid   <= 1'b1;
        s.result      <= r_c;
        s.remainder   <= rem_c;
        s.zero        <= r_c == '0;
        s.sign        <= r_c[WIDTH-1];
        s.carry       <= c_c;
        s.overflow    <= v_c;
        s.parity      <= ^r_c;
        s.div_by_zero <= dz_c;
        s.illegal_op  <= il_c;
      end
      case (state)
        IDLE: if (accept) begin
          s.in_ready <= 1'b0;
          is_mul     <= s.opcode == 4'd9;
          bq         <= s.b;
          acc        <= {{WIDTH{1'b0}}, s.a};
          cnt        <= CNT_W'(WIDTH);
          if (multi) state <= CALC;
        end
        CALC: begin
          acc <= nxt;
          cnt <= cnt - CNT_W'(1);
        end
        DONE: if (s.out_ready) begin
          s.out_valid <= 1'b0;
          s.in_ready  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
